reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Shares the single write port of the 32-bit register bank between two requesters: requester 0 is ALU writeback and requester 1 is memory load return.
- Arbitrates fairly between them, decodes the winning address, and drives the one-hot load_enable bus that feeds the reg_32_bit instances.
- Sits between the execute/memory stages and the register bank.

Parameters:
- DATA_W, 32, width of the write data and of each register.
- N_REGS, 16, number of registers; must be a power of 2.
- ADDR_W, 4, register address width; equals log2(N_REGS).

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  ALU requests a write.
- req0_addr  in  ADDR_W  ALU destination register.
- req0_data  in  DATA_W  ALU write data.
- req0_ready  out  1  ALU request accepted this cycle.
- req1_valid  in  1  memory requests a write.
- req1_addr  in  ADDR_W  memory destination register.
- req1_data  in  DATA_W  memory write data.
- req1_ready  out  1  memory request accepted this cycle.
- load_enable  out  N_REGS  one-hot per-register load strobe.
- wr_data  out  DATA_W  data driven to every register input.
- busy  out  1  a write is being presented this cycle.

Behaviour:
- Handshake:
  - A transfer occurs when reqN_valid and reqN_ready are both high on a rising clk edge.
  - reqN_ready is combinational from the valid inputs and arbiter state.
  - A requester holds valid, addr and data stable until it is accepted.
- Arbiter FSM, two states:
  - PRIO0: requester 0 wins a tie.
  - PRIO1: requester 1 wins a tie.
  - Reset state is PRIO0.
- Arbitration each cycle:
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester favoured by the current state gets ready=1; the other gets ready=0 and waits.
  - Neither valid: both ready=0 and the state is held.
- State transitions:
  - After a grant to requester 0, the next state is PRIO1.
  - After a grant to requester 1, the next state is PRIO0.
  - This guarantees that a continuously waiting requester is served within 2 cycles.
- Output stage:
  - Registered; latency is 1 cycle from acceptance.
  - On the edge that accepts a request:
    - load_enable <= one-hot decode of the winning addr.
    - wr_data <= the winning data.
    - busy <= 1.
  - A cycle with no acceptance leaves load_enable all zero and busy=0; wr_data holds its last value.
- Register 0 is hardwired zero:
  - A write to addr 0 is accepted (ready=1) and consumes its arbitration turn.
  - It produces load_enable=0 and busy=0.
- Back-to-back operation: acceptances on consecutive cycles produce strobes on consecutive cycles; throughput is 1 write per cycle.
- Simultaneous same-address writes: serialized in arbitration order, so the later-granted data is what remains in the register.
- Reset:
  - Outputs: load_enable=0, wr_data=0, busy=0, both ready=0.
  - State returns to PRIO0.
- Reset mid-operation: a pending unaccepted request is dropped by the arbiter; the requester re-presents it after reset.
- Because every write lasts exactly one cycle, no additional output (load_enable) is ever asserted for more than 1 cycle per acceptance.

Optional Feature:
- Macro: ARB_STATS_EN.
- When defined:
  - Adds output conflict_count [15:0].
  - conflict_count increments on every cycle in which both valids are high, and saturates at 16'hFFFF.
  - It is cleared by reset.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - DATA_W, N_REGS and ADDR_W defaults.
  - The arbiter state encoding: PRIO0=1'b0, PRIO1=1'b1.
  - The requester ID constants: REQ_ALU=0, REQ_MEM=1.
- Sub-module: reg_addr_decoder, which turns an ADDR_W address plus an enable into the N_REGS one-hot bus, with index 0 forced to 0.

Test Plan:
- Reset, then a single ALU write of addr 4'h3, data 32'h0000000A:
  - req0_ready=1 in the request cycle.
  - Next cycle load_enable=16'h0008, wr_data=32'h0000000A, busy=1.
- Both requesters valid for 4 cycles, ALU addr 5, memory addr 6:
  - Grants alternate 0,1,0,1.
  - load_enable sequence is 0020, 0040, 0020, 0040.
- Write to addr 0 with data 32'hFFFFFFFF:
  - ready=1.
  - Next cycle load_enable=0 and busy=0; the state still toggles.
- Memory held valid while the ALU issues a burst of writes:
  - Memory is granted within 2 cycles.
  - Memory data 32'h0000000B appears on wr_data.
- Reset asserted while both requesters are valid:
  - Outputs are 0 on the next edge.
  - After release, requester 0 wins the first tie.
- With ARB_STATS_EN defined, 3 conflict cycles: conflict_count=3; after reset it reads 0.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and defaults for the register-bank write-port arbiter.
package reg_write_arbiter_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_N_REGS = 16;
  localparam int unsigned DEF_ADDR_W = 4;

  typedef enum logic {
    PRIO0 = 1'b0,
    PRIO1 = 1'b1
  } arb_state_e;

  typedef logic req_id_t;

  localparam req_id_t REQ_ALU = 1'b0;
  localparam req_id_t REQ_MEM = 1'b1;

endpackage

// File: rtl/reg_addr_decoder.sv
// Register address to one-hot load strobe; register 0 is hardwired zero and never strobed.
module reg_addr_decoder
  import reg_write_arbiter_pkg::*;
#(
  parameter int unsigned N_REGS = DEF_N_REGS,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [N_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en && (addr != '0)) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Fair two-requester arbiter for the register-bank write port with registered one-hot strobes.
// Optional ARB_STATS_EN adds a saturating conflict_count output.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned N_REGS = DEF_N_REGS,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [N_REGS-1:0] load_enable,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       conflict_count
`endif
);

  arb_state_e        state_q;
  logic              grant0;
  logic              grant1;
  logic              accept;
  req_id_t           win_id;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic [N_REGS-1:0] win_onehot;

  // Grants are suppressed during reset so a pending request is dropped, not accepted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      grant0 = req0_valid && (!req1_valid || (state_q == PRIO0));
      grant1 = req1_valid && (!req0_valid || (state_q == PRIO1));
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 || grant1;

  always_comb begin
    win_id   = grant1 ? REQ_MEM : REQ_ALU;
    win_addr = (win_id == REQ_MEM) ? req1_addr : req0_addr;
    win_data = (win_id == REQ_MEM) ? req1_data : req0_data;
  end

  reg_addr_decoder #(
    .N_REGS(N_REGS),
    .ADDR_W(ADDR_W)
  ) u_decoder (
    .en    (accept),
    .addr  (win_addr),
    .onehot(win_onehot)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PRIO0;
      load_enable <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
    end else begin
      load_enable <= win_onehot;
      busy        <= accept && (win_addr != '0);
      if (accept) begin
        wr_data <= win_data;
        state_q <= (win_id == REQ_ALU) ? PRIO1 : PRIO0;
      end
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_count <= '0;
    end else if (req0_valid && req1_valid && (conflict_count != 16'hFFFF)) begin
      conflict_count <= conflict_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed-vector bench for reg_write_arbiter; define ARB_STATS_EN to also cover conflict_count.
module tb_reg_write_arbiter;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned N_REGS = 16;
  localparam int unsigned ADDR_W = 4;

  logic              clk;
  logic              reset;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic [N_REGS-1:0] load_enable;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
`ifdef ARB_STATS_EN
  logic [15:0]       conflict_count;
`endif

  int n_vec;
  int n_err;

  reg_write_arbiter #(
    .DATA_W(DATA_W),
    .N_REGS(N_REGS),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .load_enable(load_enable),
    .wr_data    (wr_data),
    .busy       (busy)
`ifdef ARB_STATS_EN
    ,
    .conflict_count(conflict_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset      = 1'b1;
    req0_valid = 1'b0;
    req0_addr  = '0;
    req0_data  = '0;
    req1_valid = 1'b0;
    req1_addr  = '0;
    req1_data  = '0;
    step();
    step();

    // Reset state; ready must stay low even with a valid request.
    req0_valid = 1'b1;
    #1;
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_le", 32'(load_enable), 32'h0);
    check("rst_wr_data", wr_data, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    req0_valid = 1'b0;
    reset = 1'b0;
    step();

    // Single ALU write.
    req0_valid = 1'b1;
    req0_addr  = 4'h3;
    req0_data  = 32'h0000000A;
    #1;
    check("t1_ready0", 32'(req0_ready), 32'd1);
    check("t1_ready1", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 1'b0;
    check("t1_le", 32'(load_enable), 32'h0008);
    check("t1_wr_data", wr_data, 32'h0000000A);
    check("t1_busy", 32'(busy), 32'd1);
    step();
    check("t1_idle_le", 32'(load_enable), 32'h0);
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_idle_hold", wr_data, 32'h0000000A);

    // Memory write to addr 0 (state is PRIO1 after the ALU grant).
    req1_valid = 1'b1;
    req1_addr  = 4'h0;
    req1_data  = 32'hFFFFFFFF;
    #1;
    check("t3_ready1", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    check("t3_le", 32'(load_enable), 32'h0);
    check("t3_busy", 32'(busy), 32'd0);

    // Both valid for 4 cycles; addr-0 write toggled state back to PRIO0.
    req0_valid = 1'b1;
    req0_addr  = 4'h5;
    req0_data  = 32'h00000050;
    req1_valid = 1'b1;
    req1_addr  = 4'h6;
    req1_data  = 32'h00000060;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t2_ready0_%0d", i), 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("t2_ready1_%0d", i), 32'(req1_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      step();
      check($sformatf("t2_le_%0d", i), 32'(load_enable), (i % 2 == 0) ? 32'h0020 : 32'h0040);
      check($sformatf("t2_wd_%0d", i), wr_data, (i % 2 == 0) ? 32'h50 : 32'h60);
    end

    // ALU burst while memory waits; memory must win within 2 cycles.
    req0_addr  = 4'h2;
    req0_data  = 32'h00000020;
    req1_addr  = 4'h7;
    req1_data  = 32'h0000000B;
    #1;
    check("t4_c0_ready0", 32'(req0_ready), 32'd1);
    check("t4_c0_ready1", 32'(req1_ready), 32'd0);
    step();
    check("t4_c0_le", 32'(load_enable), 32'h0004);
    #1;
    check("t4_c1_ready0", 32'(req0_ready), 32'd0);
    check("t4_c1_ready1", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    check("t4_c1_le", 32'(load_enable), 32'h0080);
    check("t4_c1_wd", wr_data, 32'h0000000B);
    #1;
    check("t4_c2_ready0", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    check("t4_c2_le", 32'(load_enable), 32'h0004);
    check("t4_c2_wd", wr_data, 32'h00000020);

    // Reset while both valid (state is PRIO1 here).
    req0_valid = 1'b1;
    req0_addr  = 4'h5;
    req0_data  = 32'h00000055;
    req1_valid = 1'b1;
    req1_addr  = 4'h6;
    req1_data  = 32'h00000066;
    reset      = 1'b1;
    #1;
    check("t5_rst_ready0", 32'(req0_ready), 32'd0);
    check("t5_rst_ready1", 32'(req1_ready), 32'd0);
    step();
    check("t5_rst_le", 32'(load_enable), 32'h0);
    check("t5_rst_wd", wr_data, 32'h0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    #1;
    check("t5_tie_ready0", 32'(req0_ready), 32'd1);
    check("t5_tie_ready1", 32'(req1_ready), 32'd0);
    step();
    check("t5_tie_le", 32'(load_enable), 32'h0020);
    check("t5_tie_wd", wr_data, 32'h00000055);

`ifdef ARB_STATS_EN
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    check("cc_rst", 32'(conflict_count), 32'd0);
    reset = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    step();
    step();
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    check("cc_three", 32'(conflict_count), 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("cc_cleared", 32'(conflict_count), 32'd0);
`endif

    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
